change_dispenser: RTL and testbench
===================================

# change_dispenser

Change-return stage of the vending machine. It accepts a change amount in cents from the machine controller and pays it out one coin at a time to the coin hopper mechanism. Each coin is held until the hopper acknowledges it. Selection is greedy (quarter, dime, nickel) and skips any empty hopper. The controller sends the amount; this block drives the mechanism and reports completion or a shortfall.

## Interface
Parameters:
- AMT_W, 8, width of amount and remaining-balance paths (cents, unsigned)
- TIMEOUT, 15, maximum cycles to wait for coin_ack before aborting (1..255)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- req  input  1  start request; sampled only in IDLE
- amount  input  AMT_W  change to pay, in cents; latched when req is accepted
- q_empty  input  1  quarter hopper empty
- d_empty  input  1  dime hopper empty
- n_empty  input  1  nickel hopper empty
- coin_ack  input  1  hopper has released the currently requested coin
- quarter  output  1  request one 25c coin (held until ack or timeout)
- dime  output  1  request one 10c coin
- nickel  output  1  request one 5c coin
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse: full amount paid
- err  output  1  one-cycle pulse: payout aborted
- remaining  output  AMT_W  unpaid balance register

## Operation
- States: IDLE, SELECT, WAIT_ACK, DONE, ERR. All outputs are registered.
- Reset (rst=0, asynchronous): state=IDLE; rem=0; timer=0; quarter, dime, nickel, done, err = 0; busy=0; remaining=0. The coin outputs drop immediately, even in the middle of a payout.
- IDLE:
  - If req=1: rem <= amount, go to SELECT.
  - req is ignored in every other state.
- SELECT:
  - If rem==0: go to DONE.
  - Else pick the first coin that satisfies value <= rem and is not empty, in the order 25, 10, 5.
  - Assert exactly that coin output, clear timer, go to WAIT_ACK.
  - If no coin qualifies: go to ERR.
  - This covers amounts that are not multiples of 5 and the case of all usable hoppers empty.
- WAIT_ACK:
  - If coin_ack=1: rem <= rem − value, drop the coin output, go to SELECT.
  - Else, when timer reaches TIMEOUT−1: drop the coin output, go to ERR. rem is not decremented.
  - Otherwise timer increments.
  - If ack and timeout happen in the same cycle, the ack wins.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1 for one cycle, then IDLE. remaining holds the unpaid balance until the next accepted req.
- remaining always mirrors rem. Subtraction never underflows, because a coin is only chosen when value <= rem.
- coin_ack is ignored outside WAIT_ACK. The empty flags are sampled only in SELECT; a change while in WAIT_ACK does not affect the current coin.
- At most one coin output is high in any cycle.

## Timing
- Edge e0 samples req=1 in IDLE; busy=1 and state=SELECT after e0.
- The coin output goes high after e1.
- An ack sampled at edge ek drops the coin after ek. The next coin goes high after ek+1, so there is always at least one low cycle between coins.
- Zero amount: done is high for the cycle after e1; the block is back in IDLE after e2.
- Timeout: the coin is high for exactly TIMEOUT cycles, then err is high for 1 cycle.
- Per-coin cost with immediate ack: 2 cycles. Total latency = 2·coins + 2 cycles from req to the end of done.

## Test plan
- Async reset: assert rst=0 between clock edges while quarter=1 in WAIT_ACK -> quarter, busy and remaining go to 0 immediately; after release, state is IDLE.
- amount=65, hoppers full, coin_ack one cycle after each coin -> quarter, quarter, dime, nickel, with a low cycle between coins -> done pulse, remaining=0, busy low afterwards.
- amount=30, q_empty=1 -> dime, dime, dime -> done. A req pulse with amount=50 during the payout is ignored.
- amount=0 -> no coin output, done high exactly 2 cycles after req is sampled.
- amount=12 -> dime, then rem=2 -> err pulse, remaining=2, no nickel issued.
- amount=25, coin_ack held 0, TIMEOUT=15 -> quarter high for 15 cycles, then err, remaining=25. Repeat with ack on the 15th cycle -> paid, done, no err.

Source files
------------

// File: rtl/change_dispenser.sv
// Change-return stage: pays a cent amount out one coin at a time (greedy 25/10/5),
// holding each coin request until the hopper acks it or the wait times out.
module change_dispenser #(
  parameter int AMT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             q_empty,
  input  logic             d_empty,
  input  logic             n_empty,
  input  logic             coin_ack,
  output logic             quarter,
  output logic             dime,
  output logic             nickel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AMT_W-1:0] remaining
);

  localparam logic [AMT_W-1:0] V25    = AMT_W'(25);
  localparam logic [AMT_W-1:0] V10    = AMT_W'(10);
  localparam logic [AMT_W-1:0] V5     = AMT_W'(5);
  localparam logic [7:0]       T_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SELECT, WAIT_ACK, DONE, ERR} state_t;

  state_t           state;
  logic [AMT_W-1:0] rem;
  logic [7:0]       timer;
  logic [AMT_W-1:0] coin_val;

  // The coin being requested is identified by whichever output is held high.
  always_comb begin
    coin_val = V5;
    if (quarter)   coin_val = V25;
    else if (dime) coin_val = V10;
  end

  assign remaining = rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rem     <= '0;
      timer   <= '0;
      quarter <= 1'b0;
      dime    <= 1'b0;
      nickel  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            rem   <= amount;
            busy  <= 1'b1;
            state <= SELECT;
          end
        end
        SELECT: begin
          timer <= '0;
          if (rem == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (!q_empty && rem >= V25) begin
            quarter <= 1'b1;
            state   <= WAIT_ACK;
          end else if (!d_empty && rem >= V10) begin
            dime  <= 1'b1;
            state <= WAIT_ACK;
          end else if (!n_empty && rem >= V5) begin
            nickel <= 1'b1;
            state  <= WAIT_ACK;
          end else begin
            err   <= 1'b1;
            state <= ERR;
          end
        end
        WAIT_ACK: begin
          // Ack is checked first so it wins over a simultaneous timeout.
          if (coin_ack) begin
            rem     <= rem - coin_val;
            quarter <= 1'b0;
            dime    <= 1'b0;
            nickel  <= 1'b0;
            state   <= SELECT;
          end else if (timer == T_LAST) begin
            quarter <= 1'b0;
            dime    <= 1'b0;
            nickel  <= 1'b0;
            err     <= 1'b1;
            state   <= ERR;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: coin sequences, timing of done/err, timeout
// behaviour and asynchronous reset, with hand-computed expectations.
module tb_change_dispenser;

  logic       clk = 1'b0, rst = 1'b0, req = 1'b0;
  logic [7:0] amount = 8'd0;
  logic       q_empty = 1'b0, d_empty = 1'b0, n_empty = 1'b0, coin_ack = 1'b0;
  logic       quarter, dime, nickel, busy, done, err;
  logic [7:0] remaining;

  change_dispenser #(.AMT_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .amount(amount),
    .q_empty(q_empty), .d_empty(d_empty), .n_empty(n_empty), .coin_ack(coin_ack),
    .quarter(quarter), .dime(dime), .nickel(nickel),
    .busy(busy), .done(done), .err(err), .remaining(remaining)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] a);
    amount = a;
    req    = 1'b1;
    step();
    req    = 1'b0;
  endtask

  // Observed payout: coin sequence encoded base-4 (Q=1, D=2, N=3), index of the
  // first done/err cycle counted from the cycle after req was sampled.
  int seq, done_at, err_at, done_n, err_n, max_hi, overlap, b2b;

  task automatic pay(input int ack_at, input int req_at, input int budget);
    int hi, prev, cur;
    bit fin;
    hi = 0; prev = 0; fin = 0;
    seq = 0; done_at = -1; err_at = -1; done_n = 0; err_n = 0;
    max_hi = 0; overlap = 0; b2b = 0;
    for (int c = 0; c < budget && !fin; c++) begin
      cur = quarter ? 1 : dime ? 2 : nickel ? 3 : 0;
      if (int'(quarter) + int'(dime) + int'(nickel) > 1) overlap++;
      if (cur != 0) begin
        if (prev == 0) begin
          seq = seq * 4 + cur;
          hi  = 0;
        end else if (prev != cur) b2b++;
        hi++;
        if (hi > max_hi) max_hi = hi;
      end
      coin_ack = (cur != 0 && ack_at != 0 && hi == ack_at);
      if (done) begin done_n++; if (done_at < 0) done_at = c; end
      if (err)  begin err_n++;  if (err_at < 0)  err_at = c;  end
      if (!busy) fin = 1;
      req = (c == req_at);
      if (c == req_at) amount = 8'd50;
      prev = cur;
      if (!fin) step();
    end
    coin_ack = 1'b0;
    req      = 1'b0;
    chk("pay_finished", fin, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_coins", {quarter, dime, nickel}, 0);
    chk("rst_flags", {done, err}, 0);
    chk("rst_remaining", remaining, 0);
    #2 rst = 1'b1;
    step();
    chk("rst_idle", busy, 0);

    // Asynchronous reset mid-payout
    start(8'd25);
    chk("ar_busy_sel", busy, 1);
    step();
    chk("ar_q_on", quarter, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_q_off", quarter, 0);
    chk("ar_busy_off", busy, 0);
    chk("ar_rem_off", remaining, 0);
    #1 rst = 1'b1;
    step();
    chk("ar_idle", busy, 0);

    // 65c, all hoppers full: Q Q D N
    start(8'd65);
    pay(1, -1, 60);
    chk("p65_seq", seq, 91);
    chk("p65_done_at", done_at, 9);
    chk("p65_done_n", done_n, 1);
    chk("p65_err_n", err_n, 0);
    chk("p65_max_hi", max_hi, 1);
    chk("p65_overlap", overlap, 0);
    chk("p65_b2b", b2b, 0);
    chk("p65_rem", remaining, 0);

    // 30c, quarters empty: D D D; stray req mid-payout is ignored
    q_empty = 1'b1;
    start(8'd30);
    pay(1, 3, 60);
    chk("p30_seq", seq, 42);
    chk("p30_done_at", done_at, 7);
    chk("p30_rem", remaining, 0);
    step();
    chk("p30_req_ignored", busy, 0);
    q_empty = 1'b0;

    // Zero amount
    start(8'd0);
    pay(1, -1, 20);
    chk("p0_seq", seq, 0);
    chk("p0_done_at", done_at, 1);
    chk("p0_done_n", done_n, 1);

    // 12c: one dime then shortfall of 2
    start(8'd12);
    pay(1, -1, 30);
    chk("p12_seq", seq, 2);
    chk("p12_err_at", err_at, 3);
    chk("p12_err_n", err_n, 1);
    chk("p12_done_n", done_n, 0);
    chk("p12_rem", remaining, 2);
    repeat (2) step();
    chk("p12_rem_hold", remaining, 2);

    // 25c, never acked: quarter held TIMEOUT cycles then err
    start(8'd25);
    pay(0, -1, 40);
    chk("pto_seq", seq, 1);
    chk("pto_max_hi", max_hi, 15);
    chk("pto_err_at", err_at, 16);
    chk("pto_rem", remaining, 25);

    // 25c, ack on the last allowed cycle: ack wins
    start(8'd25);
    pay(15, -1, 40);
    chk("pak_seq", seq, 1);
    chk("pak_max_hi", max_hi, 15);
    chk("pak_done_at", done_at, 17);
    chk("pak_err_n", err_n, 0);
    chk("pak_rem", remaining, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
